multicycle_control: RTL

Main control finite-state machine (FSM) for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives all datapath enables. These include `PCWrite`/`PCWriteCond`/`PCSource`, which feed the program counter and its next-address mux. It also keeps a retired-instruction count and flags unsupported opcodes.

---
 rtl/cpu_pkg.sv | 142 ++++++++++++++
 rtl/multicycle_control.sv | 111 +++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared control encodings for the multicycle MIPS datapath.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
//
// Contents: the 4-bit FSM state encoding, opcode constants, the ALUOp,
// PCSource and ALUSrcB encodings, and the control-word struct together
// with a Moore decode function that maps a state to its control word.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDI   = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  // Opcode field, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU operation select handed to the ALU control block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  // Next-PC mux select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B-operand mux select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // States whose exit completes (retires) an instruction
  function automatic logic is_terminal(input state_t s);
    case (s)
      S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: is_terminal = 1'b1;
      default:                                             is_terminal = 1'b0;
    endcase
  endfunction

  // Moore output decode: control word asserted while in state s
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMMSH;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_ADDI: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADDI;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Latency: outputs registered, valid in the same cycle the state is entered; 2-5 cycles per instruction.
// Backpressure: none; the FSM free-runs and never stalls.
//
// Ports:
//   clk, reset (async active-low)   clock and reset
//   Opcode[5:0]                     IR[31:26], looked at only in DECODE and MEMADR
//   PCWrite, PCWriteCond, PCSource  program-counter load and next-PC select
//   IorD, MemRead, MemWrite         memory address select and strobes
//   IRWrite                         instruction register load
//   MemtoReg, RegDst, RegWrite      register-file controls
//   ALUSrcA, ALUSrcB, ALUOp         ALU operand selects and operation
//   IllegalOp                       sticky unsupported-opcode flag
//   Retired[CNT_W-1:0]              retired-instruction count, wraps silently
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] Retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  logic   illegal_d;

  // Next-state logic; the opcode only steers DECODE and MEMADR
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Only sw diverts to the write path; anything else takes the load path
      S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_ADDI:   state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // State, registered control word, sticky flag and retire counter.
  // The control word is decoded from the next state so it lines up with
  // the state register while remaining a pure function of state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT;
      ctrl_q    <= '0;
      IllegalOp <= 1'b0;
      Retired   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
      if (illegal_d) begin
        IllegalOp <= 1'b1;
      end
      if (is_terminal(state_q)) begin
        Retired <= Retired + CNT_ONE;
      end
    end
  end

  assign PCWrite     = ctrl_q.pc_write;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign PCSource    = ctrl_q.pc_source;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign IRWrite     = ctrl_q.ir_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign RegDst      = ctrl_q.reg_dst;
  assign RegWrite    = ctrl_q.reg_write;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;

endmodule
